// File: rtl/mcu51_bus_master.sv
// 8051-style multiplexed AD bus master: ALE / HOLD / strobe / recovery phases.
// Optional write-verify readback when MCU51_BM_WRVERIFY_EN is defined.
module mcu51_bus_master #(
    parameter int TPH = 4
) (
    input  logic       gClk,
    input  logic       gRst,
    input  logic       Start,
    input  logic       RnW,
    input  logic [7:0] Addr,
    input  logic [7:0] WData,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] RData,
    output logic       Mismatch,
    output logic       ALE,
    output logic       WR,
    output logic       RD,
    output logic [7:0] AD_O,
    output logic       AD_OE,
    input  logic [7:0] AD_I
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_HOLD,
        S_STROBE,
        S_RECOV
`ifdef MCU51_BM_WRVERIFY_EN
        ,
        S_VERIFY
`endif
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(TPH - 1);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_half;
    logic       r_rnw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_rdata;
    logic       r_ale;
    logic       r_wr;
    logic       r_rd;
    logic [7:0] r_ad_o;
    logic       r_ad_oe;
`ifdef MCU51_BM_WRVERIFY_EN
    logic       r_vfy;
    logic       r_mismatch;
`endif

    logic       w_last;
    logic       w_rd_cyc;

    assign w_last = (r_cnt == 4'd0);

`ifdef MCU51_BM_WRVERIFY_EN
    assign w_rd_cyc = r_rnw | r_vfy;
`else
    assign w_rd_cyc = r_rnw;
`endif

    // STROBE spans 2*TPH cycles as two TPH halves so the 4-bit counter never wraps
    always_ff @(posedge gClk) begin
        if (gRst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_half  <= 1'b0;
            r_rnw   <= 1'b0;
            r_addr  <= 8'h00;
            r_wdata <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
            r_ale   <= 1'b0;
            r_wr    <= 1'b1;
            r_rd    <= 1'b1;
            r_ad_o  <= 8'h00;
            r_ad_oe <= 1'b0;
`ifdef MCU51_BM_WRVERIFY_EN
            r_vfy      <= 1'b0;
            r_mismatch <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state != S_IDLE && !w_last) begin
                r_cnt <= r_cnt - 4'd1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_state <= S_ADDR;
                        r_cnt   <= LP_LAST;
                        r_rnw   <= RnW;
                        r_addr  <= Addr;
                        r_wdata <= WData;
                        r_busy  <= 1'b1;
                        r_ale   <= 1'b1;
                        r_ad_oe <= 1'b1;
                        r_ad_o  <= Addr;
`ifdef MCU51_BM_WRVERIFY_EN
                        r_vfy      <= 1'b0;
                        r_mismatch <= 1'b0;
`endif
                    end
                end
                S_ADDR: begin
                    if (w_last) begin
                        r_state <= S_HOLD;
                        r_cnt   <= LP_LAST;
                        r_ale   <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (w_last) begin
                        r_state <= S_STROBE;
                        r_cnt   <= LP_LAST;
                        r_half  <= 1'b0;
                        if (w_rd_cyc) begin
                            r_rd    <= 1'b0;
                            r_ad_oe <= 1'b0;
                        end else begin
                            r_wr   <= 1'b0;
                            r_ad_o <= r_wdata;
                        end
                    end
                end
                S_STROBE: begin
                    if (w_last) begin
                        if (!r_half) begin
                            r_half <= 1'b1;
                            r_cnt  <= LP_LAST;
                        end else begin
                            r_state <= S_RECOV;
                            r_cnt   <= LP_LAST;
                            r_half  <= 1'b0;
                            r_wr    <= 1'b1;
                            r_rd    <= 1'b1;
                            if (w_rd_cyc) begin
                                r_rdata <= AD_I;
                            end
                        end
                    end
                end
                S_RECOV: begin
                    if (w_last) begin
`ifdef MCU51_BM_WRVERIFY_EN
                        if (!r_rnw && !r_vfy) begin
                            // readback reuses HOLD/STROBE/RECOV; VERIFY is its ALE phase
                            r_state <= S_VERIFY;
                            r_cnt   <= LP_LAST;
                            r_vfy   <= 1'b1;
                            r_ale   <= 1'b1;
                            r_ad_oe <= 1'b1;
                            r_ad_o  <= r_addr;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_ad_oe <= 1'b0;
                            r_ad_o  <= 8'h00;
                            if (r_vfy) begin
                                r_mismatch <= (r_rdata != r_wdata);
                            end
                        end
`else
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_ad_oe <= 1'b0;
                        r_ad_o  <= 8'h00;
`endif
                    end
                end
`ifdef MCU51_BM_WRVERIFY_EN
                S_VERIFY: begin
                    if (w_last) begin
                        r_state <= S_HOLD;
                        r_cnt   <= LP_LAST;
                        r_ale   <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Busy  = r_busy;
    assign Done  = r_done;
    assign RData = r_rdata;
    assign ALE   = r_ale;
    assign WR    = r_wr;
    assign RD    = r_rd;
    assign AD_O  = r_ad_o;
    assign AD_OE = r_ad_oe;

`ifdef MCU51_BM_WRVERIFY_EN
    assign Mismatch = r_mismatch;
`else
    assign Mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mcu51_bus_master.sv
// Scoreboard bench for mcu51_bus_master with an AD-bus slave memory model.
// Expected read/verify data is queued at issue time and popped at each Done.
module tb_mcu51_bus_master;

    localparam int TPH = 4;
    localparam int RDB = 5 * TPH;
`ifdef MCU51_BM_WRVERIFY_EN
    localparam int WRB = 10 * TPH;
    localparam bit VF  = 1'b1;
`else
    localparam int WRB = 5 * TPH;
    localparam bit VF  = 1'b0;
`endif

    logic       gClk = 1'b0;
    logic       gRst = 1'b1;
    logic       Start = 1'b0;
    logic       RnW = 1'b0;
    logic [7:0] Addr = 8'h00;
    logic [7:0] WData = 8'h00;
    logic       Busy, Done, Mismatch, ALE, WR, RD, AD_OE;
    logic [7:0] RData, AD_O, AD_I;

    mcu51_bus_master #(.TPH(TPH)) dut (
        .gClk(gClk), .gRst(gRst), .Start(Start), .RnW(RnW),
        .Addr(Addr), .WData(WData), .Busy(Busy), .Done(Done),
        .RData(RData), .Mismatch(Mismatch), .ALE(ALE), .WR(WR),
        .RD(RD), .AD_O(AD_O), .AD_OE(AD_OE), .AD_I(AD_I)
    );

    always #5 gClk = ~gClk;

    // slave: latch address on ALE, store on WR low, return data while RD low
    logic [7:0] smem [256];
    logic [7:0] s_addr = 8'h00;
    bit         corrupt = 1'b0;

    always @(posedge gClk) begin
        if (ALE) s_addr <= AD_O;
        if (!WR && AD_OE) smem[s_addr] = AD_O;
    end

    assign AD_I = (!RD) ? (smem[s_addr] ^ {7'b0, corrupt}) : 8'hEE;

    typedef struct {
        logic [7:0] rdata;
        logic       mm;
        int         busy;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_rdata = 8'h00;
    int         vec = 0;
    int         miss = 0;

    logic [11:0] tr [0:127];
    logic        bz [0:127];
    int          dk [4];
    logic [7:0]  drd [4];
    logic        dmm [4];
    int          dn, busy_n, bad_strobe;

    task automatic issue(input logic rnw, input logic [7:0] a,
                         input logic [7:0] w, input bit hold);
        exp_t e;
        @(negedge gClk);
        Start = 1'b1; RnW = rnw; Addr = a; WData = w;
        if (rnw) begin
            e.rdata = smem[a] ^ {7'b0, corrupt}; e.mm = 1'b0; e.busy = RDB;
            m_rdata = e.rdata;
        end else if (VF) begin
            e.rdata = w ^ {7'b0, corrupt}; e.mm = corrupt; e.busy = WRB;
            m_rdata = e.rdata;
        end else begin
            e.rdata = m_rdata; e.mm = 1'b0; e.busy = WRB;
        end
        exp_q.push_back(e);
        @(posedge gClk);
        #1;
        RnW = ~rnw; Addr = ~a; WData = ~w;
        if (!hold) Start = 1'b0;
    endtask

    task automatic capture(input int n, input int pulse_at, input int drop_at);
        dn = 0; busy_n = 0; bad_strobe = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge gClk);
            tr[k] = {ALE, WR, RD, AD_OE, AD_O};
            bz[k] = Busy;
            if (Busy) busy_n++;
            if ((!WR && !RD) || (ALE && (!WR || !RD))) bad_strobe++;
            if (Done) begin
                if (dn < 4) begin
                    dk[dn] = k; drd[dn] = RData; dmm[dn] = Mismatch;
                end
                dn++;
            end
            if (k == pulse_at) begin
                Start = 1'b1; RnW = 1'b0; Addr = 8'h55; WData = 8'h66;
            end
            if (k == drop_at) Start = 1'b0;
        end
    endtask

    task automatic test_reset();
        gRst = 1'b1; Start = 1'b0;
        for (int i = 0; i < 256; i++) smem[i] = 8'(i) ^ 8'h5A;
        repeat (3) @(negedge gClk);
        vec++;
        if ({Busy, Done, Mismatch} !== 3'b000) begin
            miss++; $display("FAIL reset_flags got %b want 000", {Busy, Done, Mismatch});
        end
        vec++;
        if (RData !== 8'h00) begin
            miss++; $display("FAIL reset_rdata got %h want 00", RData);
        end
        vec++;
        if ({ALE, WR, RD, AD_OE, AD_O} !== 12'b0110_0000_0000) begin
            miss++; $display("FAIL reset_bus got %b want 011000000000", {ALE, WR, RD, AD_OE, AD_O});
        end
        gRst = 1'b0;
        m_rdata = 8'h00;
    endtask

    task automatic test_write();
        exp_t e;
        logic [11:0] ex;
        issue(1'b0, 8'h03, 8'hA5, 1'b0);
        capture(WRB + 5, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            ex = {logic'(k <= 4), logic'(!(k >= 9 && k <= 16)), 1'b1, 1'b1,
                  (k <= 8) ? 8'h03 : 8'hA5};
            vec++;
            if (tr[k] !== ex) begin
                miss++; $display("FAIL write_bus cyc %0d got %b want %b", k, tr[k], ex);
            end
        end
        vec++;
        if (tr[WRB + 1] !== 12'b0110_0000_0000) begin
            miss++; $display("FAIL write_idle_bus got %b want 011000000000", tr[WRB + 1]);
        end
        vec++;
        if (dn !== 1 || dk[0] !== WRB + 1) begin
            miss++; $display("FAIL write_done got n=%0d at %0d want 1 at %0d", dn, dk[0], WRB + 1);
        end
        e = exp_q.pop_front();
        vec++;
        if (busy_n !== e.busy) begin
            miss++; $display("FAIL write_busy got %0d want %0d", busy_n, e.busy);
        end
        vec++;
        if (drd[0] !== e.rdata || dmm[0] !== e.mm) begin
            miss++; $display("FAIL write_sb got %h/%b want %h/%b", drd[0], dmm[0], e.rdata, e.mm);
        end
        vec++;
        if (smem[8'h03] !== 8'hA5) begin
            miss++; $display("FAIL write_slave got %h want a5", smem[8'h03]);
        end
        vec++;
        if (bad_strobe !== 0) begin
            miss++; $display("FAIL write_strobe_overlap got %0d want 0", bad_strobe);
        end
    endtask

    task automatic test_read();
        exp_t e;
        logic [3:0] ex;
        smem[8'h10] = 8'h5C;
        issue(1'b1, 8'h10, 8'h00, 1'b0);
        capture(RDB + 5, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            ex = {logic'(k <= 4), 1'b1, logic'(!(k >= 9 && k <= 16)), logic'(k <= 8)};
            vec++;
            if (tr[k][11:8] !== ex || (k <= 8 && tr[k][7:0] !== 8'h10)) begin
                miss++; $display("FAIL read_bus cyc %0d got %b want %b_10", k, tr[k], ex);
            end
        end
        vec++;
        if (dn !== 1 || dk[0] !== 21 || busy_n !== RDB) begin
            miss++; $display("FAIL read_timing got n=%0d at %0d busy %0d want 1 at 21 busy %0d",
                             dn, dk[0], busy_n, RDB);
        end
        e = exp_q.pop_front();
        vec++;
        if (drd[0] !== e.rdata || dmm[0] !== e.mm) begin
            miss++; $display("FAIL read_sb got %h/%b want %h/%b", drd[0], dmm[0], e.rdata, e.mm);
        end
    endtask

    task automatic test_ignore();
        exp_t e;
        smem[8'h20] = 8'h77;
        issue(1'b1, 8'h20, 8'h00, 1'b0);
        capture(40, 6, 7);
        vec++;
        if (dn !== 1 || dk[0] !== 21) begin
            miss++; $display("FAIL ignore_done got n=%0d at %0d want 1 at 21", dn, dk[0]);
        end
        vec++;
        if (tr[8][7:0] !== 8'h20 || tr[12][10:9] !== 2'b10) begin
            miss++; $display("FAIL ignore_cmd got %b/%b want 20/10", tr[8][7:0], tr[12][10:9]);
        end
        vec++;
        if (bz[25] !== 1'b0) begin
            miss++; $display("FAIL ignore_restart got busy %b want 0", bz[25]);
        end
        e = exp_q.pop_front();
        vec++;
        if (drd[0] !== e.rdata) begin
            miss++; $display("FAIL ignore_sb got %h want %h", drd[0], e.rdata);
        end
    endtask

    task automatic test_reset_abort();
        issue(1'b0, 8'h40, 8'h99, 1'b0);
        repeat (10) @(negedge gClk);
        vec++;
        if (WR !== 1'b0) begin
            miss++; $display("FAIL abort_in_strobe got WR %b want 0", WR);
        end
        gRst = 1'b1;
        @(negedge gClk);
        vec++;
        if ({WR, RD, AD_OE, Busy, Done} !== 5'b11000) begin
            miss++; $display("FAIL abort_bus got %b want 11000", {WR, RD, AD_OE, Busy, Done});
        end
        gRst = 1'b0;
        void'(exp_q.pop_back());
        m_rdata = 8'h00;
        capture(30, 0, 0);
        vec++;
        if (dn !== 0 || busy_n !== 0) begin
            miss++; $display("FAIL abort_no_done got n=%0d busy %0d want 0 0", dn, busy_n);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, e2;
        int lows;
        smem[8'h10] = 8'h5C;
        smem[8'h21] = 8'hC3;
        issue(1'b1, 8'h10, 8'h00, 1'b1);
        RnW = 1'b1; Addr = 8'h21;
        e2.rdata = 8'hC3; e2.mm = 1'b0; e2.busy = RDB;
        exp_q.push_back(e2);
        m_rdata = 8'hC3;
        capture(2 * RDB + 5, 0, RDB + 2);
        vec++;
        if (dn !== 2 || dk[0] !== 21 || dk[1] !== 42) begin
            miss++; $display("FAIL b2b_done got n=%0d at %0d,%0d want 2 at 21,42", dn, dk[0], dk[1]);
        end
        lows = 0;
        for (int k = 1; k <= 41; k++) if (!bz[k]) lows++;
        vec++;
        if (lows !== 1) begin
            miss++; $display("FAIL b2b_gap got %0d idle cycles want 1", lows);
        end
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            vec++;
            if (drd[i] !== e.rdata) begin
                miss++; $display("FAIL b2b_sb%0d got %h want %h", i, drd[i], e.rdata);
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [7:0] a, v;
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(128, 255));
            v = 8'($urandom);
            if (i[0]) begin
                smem[a] = v;
                issue(1'b1, a, 8'h00, 1'b0);
                capture(RDB + 2, 0, 0);
            end else begin
                issue(1'b0, a, v, 1'b0);
                capture(WRB + 2, 0, 0);
                vec++;
                if (smem[a] !== v) begin
                    miss++; $display("FAIL rnd_slave %h got %h want %h", a, smem[a], v);
                end
            end
            e = exp_q.pop_front();
            vec++;
            if (dn !== 1 || busy_n !== e.busy || drd[0] !== e.rdata || dmm[0] !== e.mm) begin
                miss++; $display("FAIL rnd_sb%0d got n=%0d busy %0d %h/%b want busy %0d %h/%b",
                                 i, dn, busy_n, drd[0], dmm[0], e.busy, e.rdata, e.mm);
            end
        end
    endtask

`ifdef MCU51_BM_WRVERIFY_EN
    task automatic test_verify();
        exp_t e;
        corrupt = 1'b1;
        issue(1'b0, 8'h50, 8'h3C, 1'b0);
        capture(WRB + 5, 0, 0);
        vec++;
        if (busy_n !== 40 || dn !== 1 || dk[0] !== 41) begin
            miss++; $display("FAIL vfy_timing got busy %0d n=%0d at %0d want 40 1 41", busy_n, dn, dk[0]);
        end
        vec++;
        if (tr[21] !== 12'b1111_0101_0000 || tr[30][10:8] !== 3'b100) begin
            miss++; $display("FAIL vfy_bus got %b/%b want 111101010000/100", tr[21], tr[30][10:8]);
        end
        e = exp_q.pop_front();
        vec++;
        if (drd[0] !== e.rdata || dmm[0] !== e.mm) begin
            miss++; $display("FAIL vfy_bad_sb got %h/%b want %h/%b", drd[0], dmm[0], e.rdata, e.mm);
        end
        @(negedge gClk);
        vec++;
        if (Mismatch !== 1'b1) begin
            miss++; $display("FAIL vfy_hold got %b want 1", Mismatch);
        end
        corrupt = 1'b0;
        issue(1'b0, 8'h50, 8'h3C, 1'b0);
        vec++;
        if (Mismatch !== 1'b0) begin
            miss++; $display("FAIL vfy_clear got %b want 0", Mismatch);
        end
        capture(WRB + 5, 0, 0);
        e = exp_q.pop_front();
        vec++;
        if (drd[0] !== e.rdata || dmm[0] !== e.mm) begin
            miss++; $display("FAIL vfy_ok_sb got %h/%b want %h/%b", drd[0], dmm[0], e.rdata, e.mm);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef MCU51_BM_WRVERIFY_EN
        test_verify();
`endif
        vec++;
        if (exp_q.size() !== 0) begin
            miss++; $display("FAIL sb_leftover got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule

// File: doc/mcu51_bus_master.md
MCU51_BUS_MASTER -- requirements
Module: mcu51_bus_master

Interface
REQ-001 The block SHALL have parameter TPH, default 4, giving the number of gClk cycles per bus phase; legal range is 1..15.
REQ-002 The block SHALL have port gClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port gRst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port Start, input, 1 bit: request a bus cycle.
REQ-005 The block SHALL have port RnW, input, 1 bit: 1 selects a read, 0 selects a write; sampled with Start.
REQ-006 The block SHALL have port Addr, input, 8 bits: bus address; sampled with Start.
REQ-007 The block SHALL have port WData, input, 8 bits: write data; sampled with Start.
REQ-008 The block SHALL have port Busy, output, 1 bit: a transaction is in progress.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port RData, output, 8 bits: captured read data.
REQ-011 The block SHALL have port Mismatch, output, 1 bit: write-verify failure flag.
REQ-012 The block SHALL have port ALE, output, 1 bit: address latch enable, active-high.
REQ-013 The block SHALL have port WR, output, 1 bit: write strobe, active-low.
REQ-014 The block SHALL have port RD, output, 1 bit: read strobe, active-low.
REQ-015 The block SHALL have ports AD_O (output, 8 bits), AD_OE (output, 1 bit) and AD_I (input, 8 bits): the multiplexed AD bus; the tristate buffer is instantiated at top level.

Function
REQ-016 All bus outputs SHALL be registered, with no combinational path from any input to ALE, WR, RD, AD_O or AD_OE.
REQ-017 The FSM SHALL have states IDLE, ADDR, HOLD, STROBE and RECOV, plus state VERIFY when the Configuration feature is compiled in.
REQ-018 In IDLE with Start=1, the block SHALL latch RnW, Addr and WData and enter ADDR at that edge; Busy SHALL be 1 from the next cycle.
REQ-019 Start SHALL be ignored while Busy=1, and the latched command SHALL NOT change.
REQ-020 In ADDR (TPH cycles), outputs SHALL be ALE=1, AD_OE=1, AD_O=Addr.
REQ-021 In HOLD (TPH cycles), outputs SHALL be ALE=0, AD_OE=1, AD_O=Addr.
REQ-022 In STROBE (2*TPH cycles), a write SHALL drive WR=0, AD_OE=1, AD_O=WData; a read SHALL drive RD=0, AD_OE=0.
REQ-023 A read SHALL load RData from AD_I on the final STROBE cycle, on the same edge at which RD returns to 1; RData SHALL hold its value otherwise.
REQ-024 In RECOV (TPH cycles), WR and RD SHALL be 1; a write SHALL hold AD_OE=1 with AD_O=WData; a read SHALL drive AD_OE=0.
REQ-025 After RECOV the block SHALL enter IDLE; Busy SHALL be 0 and Done SHALL be 1 for exactly that first IDLE cycle.
REQ-026 A Start presented during the Done cycle SHALL be accepted.
REQ-027 One transaction SHALL occupy Busy for exactly 5*TPH cycles.
REQ-028 The phase counter SHALL be 4 bits, SHALL count down from the phase length minus 1, and SHALL advance state on reaching zero; it SHALL never wrap.
REQ-029 In IDLE, outputs SHALL be ALE=0, WR=1, RD=1, AD_OE=0, AD_O=0.
REQ-030 At no time SHALL WR=0 and RD=0 be asserted together, nor SHALL either strobe be 0 while ALE=1.

Reset
REQ-031 With gRst=1, the block SHALL on the next edge enter IDLE with Busy=0, Done=0, RData=0, Mismatch=0 and the IDLE bus values, regardless of state.
REQ-032 A transaction aborted by reset SHALL NOT produce Done.

Configuration
REQ-033 The feature SHALL be controlled by macro MCU51_BM_WRVERIFY_EN.
REQ-034 With MCU51_BM_WRVERIFY_EN defined, after a write's RECOV the block SHALL enter VERIFY and run a full read cycle (ADDR, HOLD, STROBE, RECOV) to the same Addr; Busy SHALL stay 1 for 10*TPH cycles in total.
REQ-035 With MCU51_BM_WRVERIFY_EN defined, on the resulting Done the block SHALL update RData with the readback value and set Mismatch=(readback!=WData).
REQ-036 With MCU51_BM_WRVERIFY_EN defined, Mismatch SHALL hold until the next accepted Start, where it SHALL clear; read transactions SHALL be unchanged.
REQ-037 Without MCU51_BM_WRVERIFY_EN, Mismatch SHALL be tied to 0, the VERIFY state SHALL be absent, and a write SHALL take 5*TPH cycles.

Verification
REQ-038 Scenario: TPH=4, write Addr=0x03, WData=0xA5 -> ALE high for cycles 1-4, WR low for cycles 9-16 with AD_O=0xA5, Done at cycle 21, Busy high for 20 cycles.
REQ-039 Scenario: read Addr=0x10 with the slave model driving AD_I=0x5C during RD low -> RData=0x5C at Done, AD_OE=0 from cycle 9.
REQ-040 Scenario: Start pulsed at cycle 6 of an active transaction -> ignored, and exactly one Done is produced.
REQ-041 Scenario: gRst asserted during STROBE -> next cycle WR=1, RD=1, AD_OE=0, Busy=0, and no Done.
REQ-042 Scenario: back-to-back Start held high -> a second transaction begins in the Done cycle, with no idle gap beyond that cycle.
REQ-043 Scenario: with MCU51_BM_WRVERIFY_EN, write 0x3C while the slave returns 0x3D -> Busy for 40 cycles, Mismatch=1, RData=0x3D; a matching slave gives Mismatch=0.
